// File: rtl/assist_pkg.sv
// Shared state encoding, default parameters and roll magnitude helper for the assistance controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package assist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSIST = 2'd1,
        ST_BRAKE  = 2'd2,
        ST_FAULT  = 2'd3
    } assist_state_t;

    localparam int DEF_HR_W            = 8;
    localparam int DEF_OUT_W           = 13;
    localparam int DEF_KP              = 40;
    localparam int DEF_KI              = 1;
    localparam int DEF_INT_LIM         = 4096;
    localparam int DEF_UPDATE_DIV      = 50000;
    localparam int DEF_RAMP_STEP       = 64;
    localparam int DEF_ROLL_LIMIT      = 45;
    localparam int DEF_CADENCE_TIMEOUT = 100;
    localparam int DEF_FAULT_HOLD      = 20;

    // Unsigned magnitude; -512 maps to 512, which still fits in 10 unsigned bits.
    function automatic logic [9:0] roll_mag(input logic signed [9:0] roll);
        return roll[9] ? 10'(-roll) : 10'(roll);
    endfunction

endpackage

// File: rtl/assist_slew_limiter.sv
// Output ramp register: rises by at most RAMP_STEP per tick, drops to target at once, clear forces zero.
// Latency: one clk edge from tick/clear to the registered level.
// Backpressure: none.
module assist_slew_limiter
    import assist_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             clear,
    input  logic [OUT_W-1:0] target,
    output logic [OUT_W-1:0] level
);

    logic [OUT_W-1:0] rise;

    assign rise = target - level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (clear) begin
            level <= '0;
        end else if (tick) begin
            if ((target > level) && (rise > OUT_W'(RAMP_STEP)))
                level <= level + OUT_W'(RAMP_STEP);
            else
                level <= target;
        end
    end

endmodule

// File: rtl/assistance_controller.sv
// Heart-rate PI assistance controller with cadence/brake/roll supervision; PITCH_ASSIST_EN adds a pitch boost.
// Latency: control math once per UPDATE_DIV-cycle tick; brake/roll zero the output on the next clk edge.
// Backpressure: none, inputs are sampled levels.
module assistance_controller
    import assist_pkg::*;
#(
    parameter int HR_W            = DEF_HR_W,
    parameter int OUT_W           = DEF_OUT_W,
    parameter int KP              = DEF_KP,
    parameter int KI              = DEF_KI,
    parameter int INT_LIM         = DEF_INT_LIM,
    parameter int UPDATE_DIV      = DEF_UPDATE_DIV,
    parameter int RAMP_STEP       = DEF_RAMP_STEP,
    parameter int ROLL_LIMIT      = DEF_ROLL_LIMIT,
    parameter int CADENCE_TIMEOUT = DEF_CADENCE_TIMEOUT,
    parameter int FAULT_HOLD      = DEF_FAULT_HOLD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic signed [9:0] ResolvedRoll,
    input  logic signed [9:0] ResolvedPitch,
    input  logic [HR_W-1:0]   HeartRate,
    input  logic [HR_W-1:0]   HeartRateSetPoint,
    input  logic              cadence,
    input  logic              brake,
    output logic [OUT_W-1:0]  AssistanceRequirement,
    output logic [1:0]        state,
    output logic              fault
);

    localparam int DIV_W   = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int CAD_W   = $clog2(CADENCE_TIMEOUT + 1);
    localparam int HOLD_W  = $clog2(FAULT_HOLD + 1);
    localparam int OUT_MAX = (1 << OUT_W) - 1;

    assist_state_t      st_q, st_d;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               cad_q;
    logic [CAD_W-1:0]   cad_cnt, cad_d;
    logic               pedalling;
    logic               roll_bad;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic signed [HR_W:0] err;
    logic signed [31:0] integ_q, integ_sum, integ_d;
    logic signed [31:0] target_full;
    logic [OUT_W-1:0]   target;
    logic               ramp_tick, ramp_clear;

    assign tick = (div_cnt == DIV_W'(UPDATE_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // Pedalling is judged on the post-update count so the timeout lands on the Nth silent tick.
    always_comb begin
        cad_d = cad_cnt;
        if (cadence && !cad_q)
            cad_d = '0;
        else if (tick && (cad_cnt != CAD_W'(CADENCE_TIMEOUT)))
            cad_d = cad_cnt + CAD_W'(1);
    end

    assign pedalling = (cad_d < CAD_W'(CADENCE_TIMEOUT));
    assign roll_bad  = ({22'd0, roll_mag(ResolvedRoll)} > 32'(ROLL_LIMIT));
    assign err       = $signed({1'b0, HeartRate}) - $signed({1'b0, HeartRateSetPoint});

    always_comb begin
        target_full = KP * 32'(err) + KI * integ_q;
`ifdef PITCH_ASSIST_EN
        if (ResolvedPitch > 0)
            target_full = target_full + (32'(ResolvedPitch) <<< 2);
`endif
        if (target_full < 0)
            target = '0;
        else if (target_full > OUT_MAX)
            target = '1;
        else
            target = target_full[OUT_W-1:0];
    end

`ifndef PITCH_ASSIST_EN
    logic pitch_unused;
    assign pitch_unused = ^ResolvedPitch;
`endif

    always_comb begin
        integ_sum = integ_q + 32'(err);
        if (integ_sum > INT_LIM)
            integ_d = INT_LIM;
        else if (integ_sum < -INT_LIM)
            integ_d = -INT_LIM;
        else
            integ_d = integ_sum;
    end

    // Roll fault outranks brake, brake outranks cadence.
    always_comb begin
        st_d   = st_q;
        hold_d = hold_q;
        if (roll_bad) begin
            st_d   = ST_FAULT;
            hold_d = '0;
        end else begin
            case (st_q)
                ST_FAULT: begin
                    if (tick) begin
                        if (hold_q == HOLD_W'(FAULT_HOLD - 1)) begin
                            st_d   = ST_IDLE;
                            hold_d = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_BRAKE: begin
                    if (tick && !brake)
                        st_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (brake)
                        st_d = ST_BRAKE;
                    else if (tick && pedalling)
                        st_d = ST_ASSIST;
                end
                ST_ASSIST: begin
                    if (brake)
                        st_d = ST_BRAKE;
                    else if (tick && !pedalling)
                        st_d = ST_IDLE;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    assign ramp_clear = (st_d != ST_ASSIST);
    assign ramp_tick  = tick && (st_q == ST_ASSIST) && (st_d == ST_ASSIST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_IDLE;
            hold_q  <= '0;
            cad_q   <= 1'b0;
            cad_cnt <= CAD_W'(CADENCE_TIMEOUT);
            integ_q <= '0;
        end else begin
            st_q    <= st_d;
            hold_q  <= hold_d;
            cad_q   <= cadence;
            cad_cnt <= cad_d;
            if (ramp_clear)
                integ_q <= '0;
            else if (ramp_tick)
                integ_q <= integ_d;
        end
    end

    assist_slew_limiter #(
        .OUT_W     (OUT_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_slew (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (ramp_tick),
        .clear   (ramp_clear),
        .target  (target),
        .level   (AssistanceRequirement)
    );

    assign state = st_q;
    assign fault = (st_q == ST_FAULT);

endmodule

// File: tb/tb_assistance_controller.sv
// Bench for assistance_controller: two instances (KI=0 and KI=1) with a fast control tick.
// Directed spec vectors followed by randomized stimulus against a behavioural model.
module tb_assistance_controller;

    localparam int DIV      = 4;
    localparam int CAD_TO   = 100;
    localparam int HOLD     = 20;
    localparam int ROLL_LIM = 45;
    localparam int OUT_MAX  = 8191;
    localparam int ILIM     = 4096;

    logic              clk;
    logic              reset_n;
    logic signed [9:0] roll, pitch;
    logic [7:0]        hr, sp;
    logic              cad, brk;
    logic [12:0]       out_a, out_b;
    logic [1:0]        st_a, st_b;
    logic              flt_a, flt_b;

    assistance_controller #(.UPDATE_DIV(DIV), .KI(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .ResolvedRoll(roll), .ResolvedPitch(pitch),
        .HeartRate(hr), .HeartRateSetPoint(sp), .cadence(cad), .brake(brk),
        .AssistanceRequirement(out_a), .state(st_a), .fault(flt_a)
    );

    assistance_controller #(.UPDATE_DIV(DIV)) dut_b (
        .clk(clk), .reset_n(reset_n), .ResolvedRoll(roll), .ResolvedPitch(pitch),
        .HeartRate(hr), .HeartRateSetPoint(sp), .cadence(cad), .brake(brk),
        .AssistanceRequirement(out_b), .state(st_b), .fault(flt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int ecount  = 0;

    // Behavioural model: index 0 is the KI=0 instance, index 1 the KI=1 instance.
    int m_state, m_hold, m_since;
    int m_out[2];
    int m_integ[2];
    bit m_cad_prev;

    typedef struct {
        int hr;
        int sp;
        int exp_a;
        int exp_b;
    } ramp_vec_t;

    ramp_vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_hold     = 0;
        m_since    = CAD_TO;
        m_cad_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_out[k]   = 0;
            m_integ[k] = 0;
        end
        ecount = 0;
    endtask

    task automatic model_edge(input bit tk);
        int ns, r, e, tgt, p;
        bit ped;
        if (cad && !m_cad_prev)
            m_since = 0;
        else if (tk && m_since < CAD_TO)
            m_since++;
        m_cad_prev = cad;
        ped = (m_since < CAD_TO);
        r = int'(roll);
        if (r < 0) r = -r;
        ns = m_state;
        if (r > ROLL_LIM) begin
            ns = 3;
            m_hold = 0;
        end else if (m_state == 3) begin
            if (tk) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    ns = 0;
                    m_hold = 0;
                end
            end
        end else if (brk) begin
            ns = 2;
        end else if (tk) begin
            if (m_state == 2) ns = 0;
            else if (m_state == 0 && ped) ns = 1;
            else if (m_state == 1 && !ped) ns = 0;
        end
        e = int'(hr) - int'(sp);
        p = int'(pitch);
        for (int k = 0; k < 2; k++) begin
            if (ns != 1) begin
                m_out[k]   = 0;
                m_integ[k] = 0;
            end else if (m_state == 1 && tk) begin
                tgt = 40 * e + k * m_integ[k];
`ifdef PITCH_ASSIST_EN
                if (p > 0) tgt = tgt + 4 * p;
`endif
                if (tgt < 0) tgt = 0;
                if (tgt > OUT_MAX) tgt = OUT_MAX;
                if (tgt > m_out[k] + 64) m_out[k] = m_out[k] + 64;
                else m_out[k] = tgt;
                m_integ[k] = m_integ[k] + e;
                if (m_integ[k] > ILIM) m_integ[k] = ILIM;
                if (m_integ[k] < -ILIM) m_integ[k] = -ILIM;
            end
        end
        m_state = ns;
    endtask

    task automatic clk_step();
        @(posedge clk);
        ecount++;
        model_edge(ecount % DIV == 0);
        #1;
    endtask

    task automatic run_to_tick();
        do clk_step(); while (ecount % DIV != 0);
    endtask

    task automatic pulse_cad();
        cad = 1'b1;
        clk_step();
        cad = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        release_reset();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_state_a"}, st_a, m_state);
        chk({tag, "_state_b"}, st_b, m_state);
        chk({tag, "_fault"}, flt_b, m_state == 3);
        chk({tag, "_out_a"}, out_a, m_out[0]);
        chk({tag, "_out_b"}, out_b, m_out[1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nz, exp1, exp2;
        reset_n = 1'b0;
        roll = '0; pitch = '0; hr = 8'd140; sp = 8'd140; cad = 1'b0; brk = 1'b0;
        model_reset();

        tbl[0]  = '{150, 140, 64, 64};
        tbl[1]  = '{150, 140, 128, 128};
        tbl[2]  = '{150, 140, 192, 192};
        tbl[3]  = '{150, 140, 256, 256};
        tbl[4]  = '{150, 140, 320, 320};
        tbl[5]  = '{150, 140, 384, 384};
        tbl[6]  = '{150, 140, 400, 448};
        tbl[7]  = '{150, 140, 400, 470};
        tbl[8]  = '{140, 140, 0, 80};
        tbl[9]  = '{130, 140, 0, 0};
        tbl[10] = '{150, 140, 64, 64};
        tbl[11] = '{255, 0, 128, 128};
        tbl[12] = '{140, 140, 0, 192};
        tbl[13] = '{150, 140, 64, 256};

        do_reset();
        chk("reset_state", st_a, 0);
        chk("reset_out_a", out_a, 0);
        chk("reset_out_b", out_b, 0);
        chk("reset_fault", flt_a, 0);

        // Ramp and PI response table.
        pulse_cad();
        run_to_tick();
        chk("enter_assist", st_a, 1);
        chk("enter_assist_out", out_a, 0);
        for (int i = 0; i < 14; i++) begin
            hr = 8'(tbl[i].hr);
            sp = 8'(tbl[i].sp);
            run_to_tick();
            chk($sformatf("ramp_a[%0d]", i), out_a, tbl[i].exp_a);
            chk($sformatf("ramp_b[%0d]", i), out_b, tbl[i].exp_b);
            chk($sformatf("ramp_state[%0d]", i), st_a, 1);
        end

        // Brake from ASSIST, release waits for the next tick, then re-ramp from zero.
        brk = 1'b1;
        clk_step();
        chk("brake_state", st_a, 2);
        chk("brake_out_a", out_a, 0);
        chk("brake_out_b", out_b, 0);
        clk_step();
        brk = 1'b0;
        clk_step();
        chk("brake_hold_until_tick", st_a, 2);
        clk_step();
        chk("brake_release_idle", st_a, 0);
        run_to_tick();
        chk("brake_reassist", st_a, 1);
        run_to_tick();
        chk("brake_reramp_a", out_a, 64);
        chk("brake_reramp_b", out_b, 64);

        // Roll fault at output 400, then exactly HOLD in-limit ticks to leave.
        pulse_cad();
        for (int i = 0; i < 6; i++) run_to_tick();
        chk("ramp_to_400", out_a, 400);
        roll = 10'(46);
        clk_step();
        chk("roll46_out", out_a, 0);
        chk("roll46_fault", flt_a, 1);
        chk("roll46_state", st_a, 3);
        roll = '0;
        clk_step();
        for (int i = 1; i <= HOLD; i++) begin
            run_to_tick();
            if (i == HOLD - 1) chk("fault_hold_19", st_a, 3);
            if (i == HOLD) chk("fault_exit_20", st_a, 0);
        end
        chk("fault_exit_flag", flt_a, 0);

        roll = 10'(-45);
        clk_step();
        chk("roll_neg45", flt_a, 0);
        roll = 10'(45);
        clk_step();
        chk("roll_pos45", flt_a, 0);
        roll = 10'(-512);
        clk_step();
        chk("roll_neg512", flt_a, 1);
        roll = '0;
        for (int i = 0; i < 10; i++) run_to_tick();
        chk("hold_partial", st_a, 3);
        roll = 10'(-60);
        clk_step();
        roll = '0;
        for (int i = 1; i <= HOLD; i++) begin
            run_to_tick();
            if (i == HOLD - 1) chk("hold_restart_19", st_a, 3);
            if (i == HOLD) chk("hold_restart_20", st_a, 0);
        end

        // Pitch boost only exists when the feature is built in.
`ifdef PITCH_ASSIST_EN
        exp1 = 64; exp2 = 80;
`else
        exp1 = 0;  exp2 = 0;
`endif
        do_reset();
        hr = 8'd140; sp = 8'd140; pitch = 10'(20);
        pulse_cad();
        run_to_tick();
        run_to_tick();
        chk("pitch_first", out_a, exp1);
        run_to_tick();
        chk("pitch_target", out_a, exp2);
        pitch = 10'(-20);
        run_to_tick();
        chk("pitch_negative", out_a, 0);
        pitch = '0;

        // Cadence timeout: IDLE on the 100th silent tick.
        do_reset();
        hr = 8'd150; sp = 8'd140;
        pulse_cad();
        run_to_tick();
        for (int i = 2; i <= CAD_TO; i++) begin
            run_to_tick();
            if (i == CAD_TO - 1) begin
                chk("cad_tick99_state", st_a, 1);
                chk("cad_tick99_out", out_a, 400);
            end
            if (i == CAD_TO) begin
                chk("cad_tick100_state", st_a, 0);
                chk("cad_tick100_out", out_a, 0);
            end
        end
        run_to_tick();
        chk("cad_stay_idle", st_a, 0);

        // Sustained negative error: integrator pinned at -INT_LIM.
        do_reset();
        hr = 8'd120; sp = 8'd140;
        pulse_cad();
        run_to_tick();
        nz = 0;
        for (int i = 0; i < 220; i++) begin
            if (i % 50 == 49) pulse_cad();
            run_to_tick();
            if (out_a != 0 || out_b != 0) nz++;
        end
        chk("neg_err_out_zero", nz, 0);
        chk("neg_err_state", st_b, 1);
        hr = 8'd240;
        run_to_tick();
        chk("integ_clamp_t1", out_b, 0);
        run_to_tick();
        chk("integ_clamp_t2", out_b, 4);
        run_to_tick();
        chk("integ_clamp_t3", out_b, 68);
        chk("integ_clamp_a", out_a, 192);

        // Asynchronous reset between clock edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_a", out_a, 0);
        chk("async_rst_out_b", out_b, 0);
        chk("async_rst_state", st_b, 0);
        chk("async_rst_fault", flt_b, 0);
        release_reset();

        // Randomized segments against the model.
        hr = 8'd140; sp = 8'd140; roll = '0; brk = 1'b0; cad = 1'b0;
        do_reset();
        for (int seg = 0; seg < 16; seg++) begin
            int cad_pct, brk_pct, roll_pct;
            cad_pct  = ($urandom_range(0, 3) == 0) ? 0 : 10;
            brk_pct  = ($urandom_range(0, 2) == 0) ? 4 : 0;
            roll_pct = ($urandom_range(0, 2) == 0) ? 1 : 0;
            hr = 8'($urandom_range(100, 200));
            sp = 8'($urandom_range(120, 160));
            for (int c = 0; c < 500; c++) begin
                cad = (cad_pct != 0) && ($urandom_range(0, 99) < cad_pct);
                if (brk_pct == 0) brk = 1'b0;
                else if ($urandom_range(0, 99) < brk_pct) brk = ~brk;
                if ($urandom_range(0, 99) < roll_pct) begin
                    case ($urandom_range(0, 3))
                        0: roll = 10'(46);
                        1: roll = 10'(-46);
                        2: roll = 10'(-512);
                        default: roll = 10'($urandom_range(0, 1023));
                    endcase
                end else begin
                    roll = 10'(int'($urandom_range(0, 90)) - 45);
                end
                pitch = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 99) == 0) hr = 8'($urandom_range(0, 255));
                clk_step();
                chk_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/assistance_controller.md
ASSISTANCE_CONTROLLER -- requirements
Module: assistance_controller

Interface
REQ-001 SHALL have parameter HR_W, default 8, meaning heart-rate input width.
REQ-002 SHALL have parameter OUT_W, default 13, meaning assistance output width.
REQ-003 SHALL have parameter KP, default 40, meaning proportional gain.
REQ-004 SHALL have parameter KI, default 1, meaning integral gain.
REQ-005 SHALL have parameter INT_LIM, default 4096, meaning integrator symmetric clamp.
REQ-006 SHALL have parameter UPDATE_DIV, default 50000, meaning clk cycles per control tick.
REQ-007 SHALL have parameter RAMP_STEP, default 64, meaning maximum output rise per tick.
REQ-008 SHALL have parameter ROLL_LIMIT, default 45, meaning roll magnitude fault threshold.
REQ-009 SHALL have parameter CADENCE_TIMEOUT, default 100, meaning ticks without a cadence pulse before the rider counts as not pedalling.
REQ-010 SHALL have parameter FAULT_HOLD, default 20, meaning consecutive in-limit ticks required to leave FAULT.
REQ-011 SHALL have port clk, input, 1, meaning system clock, the only clock.
REQ-012 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-013 SHALL have port ResolvedRoll, input, 10 signed, meaning IMU roll.
REQ-014 SHALL have port ResolvedPitch, input, 10 signed, meaning IMU pitch.
REQ-015 SHALL have port HeartRate, input, HR_W, meaning measured bpm.
REQ-016 SHALL have port HeartRateSetPoint, input, HR_W, meaning user target bpm.
REQ-017 SHALL have port cadence, input, 1, meaning pedal pulse, synchronous to clk.
REQ-018 SHALL have port brake, input, 1, meaning active-high brake level.
REQ-019 SHALL have port AssistanceRequirement, output, OUT_W, meaning unsigned torque demand.
REQ-020 SHALL have port state, output, 2, meaning current FSM state.
REQ-021 SHALL have port fault, output, 1, meaning high while in FAULT.

Function
REQ-022 SHALL count 0..UPDATE_DIV-1 and pulse tick for one cycle on wrap; all control arithmetic SHALL update only on tick.
REQ-023 SHALL detect cadence rising edges via a registered copy, zero the cadence counter on each edge, otherwise increment it per tick, saturating at CADENCE_TIMEOUT; pedalling = counter < CADENCE_TIMEOUT.
REQ-024 SHALL form err = HeartRate - HeartRateSetPoint as signed HR_W+1 bits; positive err raises assistance.
REQ-025 SHALL, in ASSIST on tick, add err to a signed integrator, clamped to [-INT_LIM, +INT_LIM].
REQ-026 SHALL compute target = KP*err + KI*integ at full width, clamped to [0, 2^OUT_W-1].
REQ-027 SHALL, on tick in ASSIST, raise output by at most RAMP_STEP toward target and fall to target immediately.
REQ-028 SHALL implement states IDLE=0, ASSIST=1, BRAKE=2, FAULT=3.
REQ-029 IDLE->ASSIST on tick when pedalling, brake low and no tilt; ASSIST->IDLE on tick when not pedalling.
REQ-030 Any non-FAULT state ->BRAKE on the clk edge where brake is high; BRAKE->IDLE on the first tick with brake low.
REQ-031 Any state ->FAULT on the clk edge where |ResolvedRoll| > ROLL_LIMIT (-512 treated as 512); FAULT->IDLE after FAULT_HOLD consecutive ticks in limit; an out-of-limit sample restarts the hold count.
REQ-032 Priority SHALL be fault > brake > cadence when events coincide.
REQ-033 Output SHALL be registered and zero on the clk edge following entry to IDLE, BRAKE or FAULT; the integrator SHALL clear on that same edge.

Reset
REQ-034 reset_n low SHALL asynchronously force output 0, state IDLE, fault 0, integrator 0, tick counter 0, hold count 0, cadence counter CADENCE_TIMEOUT; reset mid-ramp discards all progress.

Configuration
REQ-035 With PITCH_ASSIST_EN defined, target SHALL add max(ResolvedPitch,0)<<2 before clamping; without it, ResolvedPitch SHALL be ignored and the port retained.

Structure
REQ-036 Package assist_pkg SHALL hold the state enum and the default parameter constants.
REQ-037 Sub-module assist_slew_limiter SHALL hold the ramp register and REQ-027 logic, with tick, clear and target inputs.

Verification
REQ-038 HR=150, SP=140, KI=0, pedalling -> output 64,128,192,256,320,384,400 on successive ticks.
REQ-039 ResolvedRoll=46 while output=400 -> output 0 and fault=1 next clk; roll=0 -> IDLE after exactly 20 ticks.
REQ-040 brake=1 in ASSIST -> output 0 next clk, state=2; release -> IDLE at next tick, re-ramp from 0.
REQ-041 cadence stops -> ASSIST->IDLE at the 100th tick with no pulse, output 0.
REQ-042 HR=120, SP=140 sustained -> integrator clamps at -4096, output stays 0; pitch=20 with PITCH_ASSIST_EN and HR=SP, integ=0 -> target 80.
REQ-043 reset_n low mid-ramp, asynchronous to clk -> all outputs 0 before the next clk edge.
